// File: rtl/lfsr16_pkg.sv
// Shared types and LFSR definition for the 16-bit XNOR PRBS checker.
// Feedback taps are Q[15], Q[14], Q[12], Q[3]; the new bit enters Q[0].
package lfsr16_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 14;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 3;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic lfsr16_next_bit(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
  endfunction

endpackage

// File: rtl/lfsr16_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Reset is synchronous and active-low.
module lfsr16_sat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {W{1'b1}})) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr16_checker.sv
// Self-synchronising receive checker for the 16-bit XNOR PRBS stream.
// Optional macro LFSR16_CHK_FIRST_ERR_EN enables capture of the first error index.
module lfsr16_checker
  import lfsr16_pkg::*;
#(
  parameter int SYNC_LEN    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_din,
  input  logic             i_din_valid,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_first_err_idx
);

  // state  | meaning
  // FILL   | loading 16 received bits into the shadow register
  // VERIFY | shadow tracks din; counting consecutive correct predictions
  // LOCKED | shadow free-runs on its own prediction; errors are counted

  localparam logic [7:0]  SYNC_LAST = 8'(SYNC_LEN);
  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [16:0] LOSS_LIM  = 17'(LOSS_THRESH);

  state_t             r_state;
  logic [LFSR_W-1:0]  r_shadow;
  logic [3:0]         r_fill_cnt;
  logic [7:0]         r_match_cnt;
  logic [15:0]        r_window_cnt;
  logic [15:0]        r_win_err;
  logic               r_locked;
  logic               r_err_pulse;

  logic               w_pred;
  logic               w_mismatch;
  logic               w_bit_evt;
  logic               w_err_evt;
  logic [7:0]         w_match_inc;
  logic [16:0]        w_win_err_sum;
  logic [CNT_W-1:0]   w_bit_count;

  assign w_pred        = lfsr16_next_bit(r_shadow);
  assign w_mismatch    = (i_din != w_pred);
  assign w_bit_evt     = i_din_valid && (r_state == LOCKED);
  assign w_err_evt     = w_bit_evt && w_mismatch;
  assign w_match_inc   = r_match_cnt + 8'd1;
  assign w_win_err_sum = {1'b0, r_win_err} + 17'(w_mismatch);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= FILL;
      r_shadow     <= '0;
      r_fill_cnt   <= '0;
      r_match_cnt  <= '0;
      r_window_cnt <= '0;
      r_win_err    <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (i_din_valid) begin
        case (r_state)
          FILL: begin
            r_shadow <= {r_shadow[LFSR_W-2:0], i_din};
            if (r_fill_cnt == 4'd15) begin
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
              r_state     <= VERIFY;
            end else begin
              r_fill_cnt <= r_fill_cnt + 4'd1;
            end
          end
          VERIFY: begin
            r_shadow <= {r_shadow[LFSR_W-2:0], i_din};
            if (w_mismatch) begin
              r_match_cnt <= '0;
            end else if (r_shadow != {LFSR_W{1'b1}}) begin
              // all-ones is the XNOR lock-up state, so its matches prove nothing
              if (w_match_inc == SYNC_LAST) begin
                r_state      <= LOCKED;
                r_locked     <= 1'b1;
                r_match_cnt  <= '0;
                r_window_cnt <= '0;
                r_win_err    <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end
          end
          LOCKED: begin
            r_shadow    <= {r_shadow[LFSR_W-2:0], w_pred};
            r_err_pulse <= w_mismatch;
            if (r_window_cnt == WIN_LAST) begin
              r_window_cnt <= '0;
              r_win_err    <= '0;
            end else begin
              r_window_cnt <= r_window_cnt + 16'd1;
              r_win_err    <= w_win_err_sum[15:0];
            end
            if (w_win_err_sum >= LOSS_LIM) begin
              r_state    <= FILL;
              r_locked   <= 1'b0;
              r_fill_cnt <= '0;
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  lfsr16_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_inc   (w_err_evt),
    .o_cnt   (o_err_count)
  );

  lfsr16_sat_cnt #(.W(CNT_W)) u_bit_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_inc   (w_bit_evt),
    .o_cnt   (w_bit_count)
  );

  assign o_bit_count = w_bit_count;
  assign o_locked    = r_locked;
  assign o_err_pulse = r_err_pulse;

`ifdef LFSR16_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] r_first_err_idx;
  logic             r_first_seen;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_first_err_idx <= '0;
      r_first_seen    <= 1'b0;
    end else if (i_clear) begin
      r_first_err_idx <= '0;
      r_first_seen    <= 1'b0;
    end else if (w_err_evt && !r_first_seen) begin
      r_first_err_idx <= w_bit_count;
      r_first_seen    <= 1'b1;
    end
  end

  assign o_first_err_idx = r_first_err_idx;
`else
  assign o_first_err_idx = '0;
`endif

endmodule

// File: doc/lfsr16_checker.md
Name: lfsr16_checker

Overview:
- Receive-side PRBS checker for the 16-bit XNOR Fibonacci LFSR pattern generator (feedback = ~(Q[15]^Q[14]^Q[12]^Q[3]); new bit enters Q[0] each cycle).
- Consumes the serial stream (the generator's Q[0]) one bit per valid cycle and self-synchronises to it.
- Once locked, it free-runs a local copy of the generator, counts bit errors and bits checked, and declares loss of lock on excessive errors.
- Sits at the far end of a link or loopback path for pattern-based integrity testing.

Parameters:
SYNC_LEN, 32, consecutive correct predictions required to declare lock (1..255).
WINDOW, 64, bits per loss-of-lock evaluation window while locked (2..65535).
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WINDOW).
CNT_W, 32, width of the err_count and bit_count statistics counters.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
din  in  1  received pattern bit.
din_valid  in  1  din is sampled only when high; otherwise the block holds state.
clear  in  1  synchronous clear of err_count, bit_count and first_err_idx; lock state is unaffected.
locked  out  1  high while in LOCKED.
err_pulse  out  1  one-cycle pulse, registered, one cycle after a mismatching valid bit in LOCKED.
err_count  out  CNT_W  saturating count of mismatches in LOCKED.
bit_count  out  CNT_W  saturating count of valid bits checked in LOCKED.
first_err_idx  out  CNT_W  bit_count value at the first error since clear (feature-gated).

Behaviour:
- Reset is synchronous; it is sampled while reset==0 at a clk edge.
- Reset values: state=FILL; shadow register=16'h0000; fill/match/window counters=0; all outputs=0.
- Priority per cycle: reset > clear > normal operation. clear in the same cycle as an error: counters go to 0, and the error is not counted.
- Prediction: p = ~(s[15]^s[14]^s[12]^s[3]), where s is the shadow register.
- FILL: on each valid bit, s <= {s[14:0], din}; fill_cnt increments. After the 16th bit, go to VERIFY with match_cnt=0.
- VERIFY: on each valid bit, compare din with p, then shift in din (self-synchronising).
  - Match: match_cnt++.
  - Mismatch: match_cnt <= 0.
  - If s==16'hFFFF (XNOR lock-up state), matches are not counted.
  - When match_cnt reaches SYNC_LEN: go to LOCKED, window_cnt=0, win_err=0.
- LOCKED (flywheel): on each valid bit, shift in p, not din, so line errors do not propagate.
  - bit_count++.
  - If din != p: err_count++, win_err++, err_pulse=1 on the next cycle.
  - window_cnt wraps at WINDOW-1; at the wrap, win_err is reset to 0.
  - If win_err+this_err >= LOSS_THRESH: go to FILL on the next edge, locked falls the same edge, fill_cnt=0. Statistics hold their values.
- Counters saturate at all-ones and never wrap. bit_count and err_count saturate independently.
- locked is registered and asserts the cycle after the SYNC_LEN-th match is sampled.
- din_valid low: no state, counter or prediction change; err_pulse=0.
- Reset mid-lock: everything returns to reset values on that edge; the next valid bit is fill bit 1.

Optional Feature:
- Macro LFSR16_CHK_FIRST_ERR_EN.
- Defined: first_err_idx latches bit_count (the value before increment) at the first LOCKED error after reset or clear, then holds until the next clear or reset.
- Undefined: first_err_idx is tied to 0 and its register is not generated.

Decomposition:
- Package lfsr16_pkg holds:
  - state typedef enum {FILL, VERIFY, LOCKED};
  - LFSR_W=16 and the tap-position constants (15,14,12,3);
  - a function lfsr16_next_bit(logic [15:0]) returning the XNOR feedback bit.
- One sub-module, lfsr16_sat_cnt (parameterised width, inc/clr inputs, saturating), instantiated for err_count and bit_count.

Test Plan:
1. Clean stream: drive the generator sequence from reset (Q=0). FILL takes 16 bits, then 32 matches. locked=1 after bit 48 + 1 cycle. After 1000 more bits: bit_count=1000, err_count=0.
2. Single flips: locked, invert bits 100 and 300. Expect err_pulse exactly twice, err_count=2, locked stays 1, and no cascaded errors (flywheel). With the macro defined, first_err_idx=100.
3. Loss of lock: locked, invert 8 bits within one 64-bit window. locked falls the cycle after the 8th error, state=FILL. Lock reacquires after 48 clean bits; err_count=8 is held.
4. Stalls and all-ones: gaps of din_valid=0 injected randomly give the same counts as test 1. An all-ones input stream never achieves lock.
5. Saturation and clear: with CNT_W=4, 20 errors (LOSS_THRESH=WINDOW) give err_count=15. clear together with an error gives err_count=0 next cycle, and locked is unchanged.
6. Reset mid-lock: reset=0 for one edge while locked. All outputs are 0 the next cycle, and relock takes 48 bits.
